cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_FU, default 6, giving the number of functional-unit requesters.
REQ-002 The block SHALL have parameter CDB_WIDTH, default 4, giving the number of CDB broadcast slots per cycle.
REQ-003 The block SHALL have parameter PR_BITS, default 7, giving the physical-register tag width.
REQ-004 The block SHALL run on one clock with synchronous, active-high reset. The reset port is named reset and the clock port is named clock.
REQ-005 The port `clock` SHALL be an input, 1 bit wide, and is the system clock (all state updates on its posedge).
REQ-006 The port `reset` SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-007 The port `fu_valid` SHALL be an input, NUM_FU bits wide; bit i means FU i holds a completed result awaiting broadcast.
REQ-008 The port `fu_tag` SHALL be an input, NUM_FU*PR_BITS bits wide; bits [i*PR_BITS +: PR_BITS] hold FU i's destination physical-register tag.
REQ-009 The port `branch_squash` SHALL be an input, 1 bit wide, and signals a mispredict flush.
REQ-010 The port `fu_grant` SHALL be an output, NUM_FU bits wide; bit i means FU i wins a CDB slot this cycle (combinational).
REQ-011 The port `cdb_pr_ready` SHALL be an output, CDB_WIDTH bits wide, registered, giving per-slot broadcast-valid.
REQ-012 The ports `cdb_pr_tag_0` through `cdb_pr_tag_3` SHALL be outputs, each PR_BITS bits wide, registered, giving the broadcast tag for slots 0 through 3.

Function
REQ-013 The block SHALL keep a round-robin pointer rr_ptr in the range 0..NUM_FU-1.
REQ-014 The scan order SHALL be rr_ptr, rr_ptr+1, …, wrapping modulo NUM_FU.
REQ-015 The block SHALL grant the first min(CDB_WIDTH, popcount(fu_valid)) valid requesters in scan order, in the same cycle as the request.
REQ-016 The block SHALL never assert fu_grant[i] unless fu_valid[i] is high.
REQ-017 The block SHALL assert at most CDB_WIDTH bits of fu_grant.
REQ-018 Slot assignment SHALL be contiguous from slot 0: the k-th grantee in scan order drives slot k.
REQ-019 On the next posedge, cdb_pr_ready SHALL be thermometer-coded (0000/0001/0011/0111/1111), and each cdb_pr_tag_k SHALL carry the grantee's tag.
REQ-020 Unused slots SHALL drive tag 0 with ready 0.
REQ-021 Latency from grant to broadcast SHALL be exactly 1 cycle, with no internal buffering of results.
REQ-022 Handshake: a requester SHALL hold fu_valid and its tag stable until fu_grant is seen; the arbiter SHALL assume no requester drops an ungranted request.
REQ-023 Pointer update with any grant and at least one valid requester left ungranted: rr_ptr SHALL load the index of the first ungranted valid requester in scan order.
REQ-024 Pointer update with any grant and all valid requesters granted: rr_ptr SHALL load (last grantee + 1) mod NUM_FU.
REQ-025 Pointer update with no valid requester: rr_ptr SHALL hold.
REQ-026 Fairness: a continuously valid requester SHALL be granted within 2 cycles with defaults (bound ceil(NUM_FU/CDB_WIDTH)).
REQ-027 When branch_squash is high, fu_grant SHALL be 0 that cycle, the next-cycle cdb_pr_ready SHALL be 0 with all tags 0, and rr_ptr SHALL hold.
REQ-028 Squash SHALL take priority over all requests.
REQ-029 Wrap-around: the scan SHALL cross index NUM_FU-1 to 0 with no loss of slots.
REQ-030 Reset SHALL take priority over branch_squash and all requests.

Reset
REQ-031 While reset is high, fu_grant SHALL be 0 combinationally, regardless of fu_valid.
REQ-032 After a reset edge, rr_ptr SHALL be 0, cdb_pr_ready SHALL be 0, and cdb_pr_tag_0 through cdb_pr_tag_3 SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard that cycle's arbitration; slots registered before the reset edge are cleared at that edge.

Verification
REQ-034 The bench SHALL cover reset: reset=1, fu_valid=111111 -> fu_grant=000000; after the edge, ready=0000, all tags 0, rr_ptr=0.
REQ-035 The bench SHALL cover light load: rr_ptr=0, fu_valid=000110, tags fu1=32 and fu2=33 -> fu_grant=000110; next cycle ready=0011, tag_0=32, tag_1=33; rr_ptr=3.
REQ-036 The bench SHALL cover oversubscription: rr_ptr=0, all 6 valid, held for 2 cycles -> cycle1 grant=001111, rr_ptr=4; cycle2 grant=110011 with slot order fu4, fu5, fu0, fu1, rr_ptr=2.
REQ-037 The bench SHALL cover wrap: rr_ptr=5, fu_valid=100001, tags fu5=40 and fu0=41 -> next cycle tag_0=40, tag_1=41, ready=0011; rr_ptr=1.
REQ-038 The bench SHALL cover squash: branch_squash=1, fu_valid=001111 -> fu_grant=0; next cycle ready=0000; rr_ptr unchanged.
REQ-039 The bench SHALL cover mid-run reset: 4 slots broadcasting, then reset=1 for one cycle -> after the edge, ready=0000, rr_ptr=0, with no grant during the reset cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// -----------------------------------------------------------------------------
// Round-robin arbiter for the common data bus (CDB). Up to NUM_FU functional
// units present a completed result (valid + destination physical-register tag).
// Each cycle the first CDB_WIDTH valid requesters in round-robin scan order are
// granted combinationally. The granted tags are packed into slots 0,1,2,...
// in scan order and broadcast from registers on the next clock edge.
//
// Ports
//   clock          : system clock, all state updates on posedge
//   reset          : synchronous active-high reset; also masks fu_grant
//   fu_valid       : [NUM_FU] per-FU result-ready request
//   fu_tag         : [NUM_FU*PR_BITS] per-FU destination tag, FU i at i*PR_BITS
//   branch_squash  : mispredict flush; kills this cycle's arbitration
//   fu_grant       : [NUM_FU] combinational grant back to the FUs
//   cdb_pr_ready   : [CDB_WIDTH] registered per-slot broadcast valid
//   cdb_pr_tag_0..3: registered per-slot broadcast tag (0 when slot unused)
//
// CDB_WIDTH is expected to be at most 4, matching the four tag outputs.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_FU    = 6,
   parameter int CDB_WIDTH = 4,
   parameter int PR_BITS   = 7
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_FU-1:0]           fu_valid,
   input  logic [NUM_FU*PR_BITS-1:0]   fu_tag,
   input  logic                        branch_squash,
   output logic [NUM_FU-1:0]           fu_grant,
   output logic [CDB_WIDTH-1:0]        cdb_pr_ready,
   output logic [PR_BITS-1:0]          cdb_pr_tag_0,
   output logic [PR_BITS-1:0]          cdb_pr_tag_1,
   output logic [PR_BITS-1:0]          cdb_pr_tag_2,
   output logic [PR_BITS-1:0]          cdb_pr_tag_3
);

   localparam int PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int MAX_SLOTS = 4;

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_ptr_next;
   logic [NUM_FU-1:0]  grant_raw;
   logic [CDB_WIDTH-1:0] slot_valid;
   logic [PR_BITS-1:0] slot_tag [MAX_SLOTS];
   logic [PR_BITS-1:0] tag_q    [MAX_SLOTS];

   // Requester index visited at position 'offset' of a scan starting at 'base'.
   // offset never exceeds NUM_FU, so a single conditional subtract is enough.
   function automatic logic [PTR_W-1:0] scan_index(input logic [PTR_W-1:0] base,
                                                   input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_FU) sum = sum - NUM_FU;
      return PTR_W'(sum);
   endfunction

   // Arbitration. The requests are first rotated into scan order so that
   // position k is the k-th requester looked at from rr_ptr; the scan then
   // hands out slots in order until CDB_WIDTH are used. The first valid
   // requester that misses out is remembered so the pointer can start there
   // next cycle, which is what gives the ceil(NUM_FU/CDB_WIDTH) fairness bound.
   always_comb begin
      logic [NUM_FU-1:0]  rot_valid;
      logic [NUM_FU-1:0]  rot_grant;
      logic [PR_BITS-1:0] rot_tag [NUM_FU];
      int cnt;
      int last_k;
      int left_k;
      logic left_found;

      rot_valid  = '0;
      rot_grant  = '0;
      cnt        = 0;
      last_k     = 0;
      left_k     = 0;
      left_found = 1'b0;
      grant_raw  = '0;
      slot_valid = '0;
      for (int s = 0; s < MAX_SLOTS; s++) slot_tag[s] = '0;
      for (int k = 0; k < NUM_FU; k++) rot_tag[k] = '0;

      for (int k = 0; k < NUM_FU; k++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (scan_index(rr_ptr, k) == PTR_W'(i)) begin
               rot_valid[k] = fu_valid[i];
               rot_tag[k]   = fu_tag[i*PR_BITS +: PR_BITS];
            end
         end
      end

      for (int k = 0; k < NUM_FU; k++) begin
         if (rot_valid[k]) begin
            if (cnt < CDB_WIDTH) begin
               rot_grant[k] = 1'b1;
               for (int s = 0; s < CDB_WIDTH; s++) begin
                  if (s == cnt) begin
                     slot_valid[s] = 1'b1;
                     slot_tag[s]   = rot_tag[k];
                  end
               end
               cnt    = cnt + 1;
               last_k = k;
            end else if (!left_found) begin
               left_found = 1'b1;
               left_k     = k;
            end
         end
      end

      for (int i = 0; i < NUM_FU; i++) begin
         for (int k = 0; k < NUM_FU; k++) begin
            if (scan_index(rr_ptr, k) == PTR_W'(i)) grant_raw[i] = rot_grant[k];
         end
      end

      if (cnt == 0)
         rr_ptr_next = rr_ptr;
      else if (left_found)
         rr_ptr_next = scan_index(rr_ptr, left_k);
      else
         rr_ptr_next = scan_index(rr_ptr, last_k + 1);
   end

   // Reset and squash both suppress grants in the same cycle so no FU
   // believes its result was broadcast when it will not be.
   assign fu_grant = (reset || branch_squash) ? '0 : grant_raw;

   // Broadcast registers and pointer. Reset wins over squash; squash clears
   // the slots but leaves the pointer where it was.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr       <= '0;
         cdb_pr_ready <= '0;
         for (int s = 0; s < MAX_SLOTS; s++) tag_q[s] <= '0;
      end else if (branch_squash) begin
         cdb_pr_ready <= '0;
         for (int s = 0; s < MAX_SLOTS; s++) tag_q[s] <= '0;
      end else begin
         rr_ptr       <= rr_ptr_next;
         cdb_pr_ready <= slot_valid;
         for (int s = 0; s < MAX_SLOTS; s++) tag_q[s] <= slot_tag[s];
      end
   end

   assign cdb_pr_tag_0 = tag_q[0];
   assign cdb_pr_tag_1 = tag_q[1];
   assign cdb_pr_tag_2 = tag_q[2];
   assign cdb_pr_tag_3 = tag_q[3];

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// -----------------------------------------------------------------------------
// Directed testbench for cdb_arbiter with default parameters (6 FUs, 4 slots,
// 7-bit tags). Each step drives inputs, checks the combinational grant, clocks
// once and checks the registered broadcast slots and the round-robin pointer.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int NUM_FU    = 6;
   localparam int CDB_WIDTH = 4;
   localparam int PR_BITS   = 7;

   logic                      clock;
   logic                      reset;
   logic [NUM_FU-1:0]         fu_valid;
   logic [NUM_FU*PR_BITS-1:0] fu_tag;
   logic                      branch_squash;
   logic [NUM_FU-1:0]         fu_grant;
   logic [CDB_WIDTH-1:0]      cdb_pr_ready;
   logic [PR_BITS-1:0]        cdb_pr_tag_0;
   logic [PR_BITS-1:0]        cdb_pr_tag_1;
   logic [PR_BITS-1:0]        cdb_pr_tag_2;
   logic [PR_BITS-1:0]        cdb_pr_tag_3;

   int vectors;
   int miscompares;

   cdb_arbiter #(
      .NUM_FU   (NUM_FU),
      .CDB_WIDTH(CDB_WIDTH),
      .PR_BITS  (PR_BITS)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .fu_valid     (fu_valid),
      .fu_tag       (fu_tag),
      .branch_squash(branch_squash),
      .fu_grant     (fu_grant),
      .cdb_pr_ready (cdb_pr_ready),
      .cdb_pr_tag_0 (cdb_pr_tag_0),
      .cdb_pr_tag_1 (cdb_pr_tag_1),
      .cdb_pr_tag_2 (cdb_pr_tag_2),
      .cdb_pr_tag_3 (cdb_pr_tag_3)
   );

   // 10 time-unit clock, posedges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic setTag(input int idx, input logic [PR_BITS-1:0] value);
      fu_tag[idx*PR_BITS +: PR_BITS] = value;
   endtask

   // Drives one cycle's inputs and lets the combinational grant settle
   // well away from the next posedge.
   task automatic applyStimulus(input logic r, input logic sq,
                                input logic [NUM_FU-1:0] valid);
      reset         = r;
      branch_squash = sq;
      fu_valid      = valid;
      #2;
   endtask

   // Clocks once and samples the registered outputs 1 unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkSlots(input string name, input logic [3:0] ready,
                             input logic [6:0] t0, input logic [6:0] t1,
                             input logic [6:0] t2, input logic [6:0] t3,
                             input int ptr);
      checkOutput({name, ".ready"}, 32'(cdb_pr_ready), 32'(ready));
      checkOutput({name, ".tag0"},  32'(cdb_pr_tag_0), 32'(t0));
      checkOutput({name, ".tag1"},  32'(cdb_pr_tag_1), 32'(t1));
      checkOutput({name, ".tag2"},  32'(cdb_pr_tag_2), 32'(t2));
      checkOutput({name, ".tag3"},  32'(cdb_pr_tag_3), 32'(t3));
      checkOutput({name, ".rr_ptr"}, 32'(dut.rr_ptr), 32'(ptr));
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      reset         = 1'b1;
      branch_squash = 1'b0;
      fu_valid      = '0;
      fu_tag        = '0;
      #1;

      // Reset with everyone requesting: no grants, everything cleared.
      applyStimulus(1'b1, 1'b0, 6'b111111);
      checkOutput("rst.grant", 32'(fu_grant), 32'h0);
      tick();
      checkSlots("rst", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 0);

      // Light load: FU1 and FU2 from pointer 0.
      setTag(1, 7'd32);
      setTag(2, 7'd33);
      applyStimulus(1'b0, 1'b0, 6'b000110);
      checkOutput("light.grant", 32'(fu_grant), 32'b000110);
      tick();
      checkSlots("light", 4'b0011, 7'd32, 7'd33, 7'd0, 7'd0, 3);

      // Back to pointer 0, then oversubscribe with all six for two cycles.
      applyStimulus(1'b1, 1'b0, 6'b000000);
      tick();
      checkOutput("rst2.rr_ptr", 32'(dut.rr_ptr), 32'd0);
      for (int i = 0; i < NUM_FU; i++) setTag(i, 7'(10 + i));
      applyStimulus(1'b0, 1'b0, 6'b111111);
      checkOutput("over1.grant", 32'(fu_grant), 32'b001111);
      tick();
      checkSlots("over1", 4'b1111, 7'd10, 7'd11, 7'd12, 7'd13, 4);
      applyStimulus(1'b0, 1'b0, 6'b111111);
      checkOutput("over2.grant", 32'(fu_grant), 32'b110011);
      tick();
      checkSlots("over2", 4'b1111, 7'd14, 7'd15, 7'd10, 7'd11, 2);

      // Single requester FU4 from pointer 2 moves the pointer to 5.
      setTag(4, 7'd20);
      applyStimulus(1'b0, 1'b0, 6'b010000);
      checkOutput("single.grant", 32'(fu_grant), 32'b010000);
      tick();
      checkSlots("single", 4'b0001, 7'd20, 7'd0, 7'd0, 7'd0, 5);

      // Wrap: FU5 then FU0 from pointer 5.
      setTag(5, 7'd40);
      setTag(0, 7'd41);
      applyStimulus(1'b0, 1'b0, 6'b100001);
      checkOutput("wrap.grant", 32'(fu_grant), 32'b100001);
      tick();
      checkSlots("wrap", 4'b0011, 7'd40, 7'd41, 7'd0, 7'd0, 1);

      // Squash beats requests; pointer holds at 1.
      applyStimulus(1'b0, 1'b1, 6'b001111);
      checkOutput("squash.grant", 32'(fu_grant), 32'h0);
      tick();
      checkSlots("squash", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1);

      // Four slots broadcasting from pointer 1: order FU1, FU2, FU3, FU0.
      for (int i = 0; i < 4; i++) setTag(i, 7'(50 + i));
      applyStimulus(1'b0, 1'b0, 6'b001111);
      checkOutput("full.grant", 32'(fu_grant), 32'b001111);
      tick();
      checkSlots("full", 4'b1111, 7'd51, 7'd52, 7'd53, 7'd50, 1);

      // Mid-run reset with squash also high: reset wins, no grant.
      applyStimulus(1'b1, 1'b1, 6'b001111);
      checkOutput("midrst.grant", 32'(fu_grant), 32'h0);
      tick();
      checkSlots("midrst", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 0);

      // Idle cycle: pointer holds, nothing broadcast.
      applyStimulus(1'b0, 1'b0, 6'b000000);
      checkOutput("idle.grant", 32'(fu_grant), 32'h0);
      tick();
      checkSlots("idle", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 0);

      // Three sparse requesters give a 0111 thermometer; pointer to 5.
      setTag(0, 7'd60);
      setTag(2, 7'd62);
      setTag(4, 7'd64);
      applyStimulus(1'b0, 1'b0, 6'b010101);
      checkOutput("three.grant", 32'(fu_grant), 32'b010101);
      tick();
      checkSlots("three", 4'b0111, 7'd60, 7'd62, 7'd64, 7'd0, 5);

      applyStimulus(1'b0, 1'b0, 6'b000000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
